// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, flag/branch encodings and the execute-stage entry type.
package alu_pkg;
    localparam int EX_DATA_W = 32;
    localparam int EX_RD_W = 4;
    typedef enum logic [2:0] {
        FN_AND   = 3'b000,
        FN_OR    = 3'b001,
        FN_XOR   = 3'b010,
        FN_ADD   = 3'b011,
        FN_SUB   = 3'b100,
        FN_CMP   = 3'b101,
        FN_SHR   = 3'b110,
        FN_SHL16 = 3'b111
    } alu_fn_e;
    localparam logic [1:0] FLG_POS  = 2'b00;
    localparam logic [1:0] FLG_ZERO = 2'b01;
    localparam logic [1:0] FLG_NEG  = 2'b10;
    typedef enum logic [1:0] {
        BR_ALWAYS = 2'b00,
        BR_EQ     = 2'b01,
        BR_LT     = 2'b10,
        BR_GT     = 2'b11
    } br_cond_e;
    typedef struct packed {
        logic [EX_DATA_W-1:0] result;
        logic [EX_RD_W-1:0]   rd;
        logic                 wb_en;
        logic                 br_taken;
        logic [EX_DATA_W-1:0] br_target;
    } ex_entry_t;
    function automatic logic br_resolve(input logic [1:0] cond, input logic [1:0] flags);
        return cond == BR_ALWAYS
            || (cond == BR_EQ && flags == FLG_ZERO)
            || (cond == BR_LT && flags == FLG_NEG)
            || (cond == BR_GT && flags == FLG_POS);
    endfunction
endpackage

// File: rtl/alu_ex_stage_skid_buf2.sv
// skid_buf2: two-entry valid/ready FIFO of ex_entry_t; entry0 drives the outputs, entry1 is the skid slot.
// o_ready depends only on registered state, never on i_ready.
module skid_buf2
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_valid,
    output logic      o_ready,
    input  ex_entry_t i_data,
    output logic      o_valid,
    input  logic      i_ready,
    output ex_entry_t o_data
);
    logic      r_v0;
    logic      r_v1;
    ex_entry_t r_e0;
    ex_entry_t r_e1;
    logic      w_acc;
    logic      w_free;
    assign w_acc   = i_valid && !r_v1;
    assign w_free  = !r_v0 || i_ready;
    assign o_ready = !r_v1;
    assign o_valid = r_v0;
    assign o_data  = r_e0;
    // entry1 can only be occupied while entry0 is, so an accept never coincides with entry1 moving up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_e0 <= '0;
            r_e1 <= '0;
        end else if (w_free) begin
            if (r_v1) begin
                r_e0 <= r_e1;
                r_v0 <= 1'b1;
                r_v1 <= 1'b0;
            end else begin
                r_v0 <= w_acc;
                if (w_acc) r_e0 <= i_data;
            end
        end else if (w_acc) begin
            r_e1 <= i_data;
            r_v1 <= 1'b1;
        end
    end
endmodule

// File: rtl/alu_ex_stage.sv
// alu_ex_stage: ALU output register with flags register, branch resolution and a two-entry skid buffer.
// Optional perf counters under ALU_EX_PERF_CNT_EN.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int RD_W   = EX_RD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_func,
    input  logic [DATA_W-1:0] in_result,
    input  logic [1:0]        in_flags,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wb_en,
    input  logic              in_br_en,
    input  logic [1:0]        in_br_cond,
    input  logic [DATA_W-1:0] in_br_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wb_en,
    output logic              out_br_taken,
    output logic [DATA_W-1:0] out_br_target,
    output logic [1:0]        flags_q
`ifdef ALU_EX_PERF_CNT_EN
   ,output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_br_taken_cnt
`endif
);
    ex_entry_t w_din;
    ex_entry_t w_dout;
    logic      w_acc;
    logic      w_is_cmp;
    logic      w_taken;
    assign w_is_cmp = in_func == FN_CMP;
    assign w_acc    = in_valid && in_ready;
    // resolved against flags_q before any CMP in the same cycle updates it; CMP never branches or writes rd
    assign w_taken  = in_br_en && !w_is_cmp && br_resolve(in_br_cond, flags_q);
    assign w_din    = '{result: in_result, rd: in_rd, wb_en: in_wb_en && !w_is_cmp,
                        br_taken: w_taken, br_target: in_br_target};
    skid_buf2 u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_din),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_dout)
    );
    assign out_result    = w_dout.result;
    assign out_rd        = w_dout.rd;
    assign out_wb_en     = w_dout.wb_en;
    assign out_br_taken  = w_dout.br_taken;
    assign out_br_target = w_dout.br_target;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= FLG_POS;
        else if (w_acc && w_is_cmp) flags_q <= in_flags;
    end
`ifdef ALU_EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt    <= '0;
            perf_br_taken_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (w_acc && w_taken) perf_br_taken_cnt <= perf_br_taken_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: directed self-checking bench for alu_ex_stage.
module tb_alu_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_func = 3'b000;
    logic [31:0] in_result = '0;
    logic [1:0]  in_flags = 2'b00;
    logic [3:0]  in_rd = '0;
    logic        in_wb_en = 1'b0;
    logic        in_br_en = 1'b0;
    logic [1:0]  in_br_cond = 2'b00;
    logic [31:0] in_br_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_wb_en;
    logic        out_br_taken;
    logic [31:0] out_br_target;
    logic [1:0]  flags_q;
`ifdef ALU_EX_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_br_taken_cnt;
`endif
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_ex_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_func       (in_func),
        .in_result     (in_result),
        .in_flags      (in_flags),
        .in_rd         (in_rd),
        .in_wb_en      (in_wb_en),
        .in_br_en      (in_br_en),
        .in_br_cond    (in_br_cond),
        .in_br_target  (in_br_target),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_wb_en     (out_wb_en),
        .out_br_taken  (out_br_taken),
        .out_br_target (out_br_target),
        .flags_q       (flags_q)
`ifdef ALU_EX_PERF_CNT_EN
       ,.perf_stall_cnt    (perf_stall_cnt),
        .perf_br_taken_cnt (perf_br_taken_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] res, input logic [1:0] fl,
                        input logic [3:0] rd, input logic wb, input logic br,
                        input logic [1:0] c, input logic [31:0] tgt);
        in_valid = 1'b1; in_func = f; in_result = res; in_flags = fl; in_rd = rd;
        in_wb_en = wb; in_br_en = br; in_br_cond = c; in_br_target = tgt;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_cmp++; if (flags_q !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", flags_q); end
        n_cmp++; if ({out_result, out_rd, out_wb_en, out_br_taken, out_br_target} !== '0) begin
            n_fail++; $display("FAIL reset_data: got res=%h rd=%h wb=%b tk=%b tgt=%h want all 0",
                               out_result, out_rd, out_wb_en, out_br_taken, out_br_target);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(3'b011, 32'h5, 2'b00, 4'd3, 1'b1, 1'b0, 2'b00, 32'h0);
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %0b want 1", out_valid); end
        n_cmp++; if (out_result !== 32'h5) begin n_fail++; $display("FAIL add_result: got %h want 5", out_result); end
        n_cmp++; if (out_rd !== 4'd3) begin n_fail++; $display("FAIL add_rd: got %0d want 3", out_rd); end
        n_cmp++; if (out_wb_en !== 1'b1) begin n_fail++; $display("FAIL add_wb: got %0b want 1", out_wb_en); end
        send(3'b101, 32'h0, 2'b01, 4'd7, 1'b1, 1'b1, 2'b00, 32'h40);
        step();
        n_cmp++; if (flags_q !== 2'b01) begin n_fail++; $display("FAIL cmp_flags: got %b want 01", flags_q); end
        n_cmp++; if (out_wb_en !== 1'b0) begin n_fail++; $display("FAIL cmp_wb_forced: got %0b want 0", out_wb_en); end
        n_cmp++; if (out_br_taken !== 1'b0) begin n_fail++; $display("FAIL cmp_br_forced: got %0b want 0", out_br_taken); end
        idle();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        send(3'b101, 32'h0, 2'b10, 4'd0, 1'b0, 1'b0, 2'b00, 32'h0);
        step();
        send(3'b000, 32'h0, 2'b00, 4'd0, 1'b0, 1'b1, 2'b10, 32'h100);
        step();
        n_cmp++; if (out_br_taken !== 1'b1) begin n_fail++; $display("FAIL br_lt_taken: got %0b want 1", out_br_taken); end
        n_cmp++; if (out_br_target !== 32'h100) begin n_fail++; $display("FAIL br_lt_target: got %h want 100", out_br_target); end
        send(3'b000, 32'h0, 2'b00, 4'd0, 1'b0, 1'b1, 2'b01, 32'h200);
        step();
        n_cmp++; if (out_br_taken !== 1'b0) begin n_fail++; $display("FAIL br_eq_nottaken: got %0b want 0", out_br_taken); end
        send(3'b000, 32'h0, 2'b00, 4'd0, 1'b0, 1'b1, 2'b00, 32'h300);
        step();
        n_cmp++; if (out_br_taken !== 1'b1) begin n_fail++; $display("FAIL br_always: got %0b want 1", out_br_taken); end
        send(3'b000, 32'h0, 2'b00, 4'd0, 1'b0, 1'b0, 2'b00, 32'h340);
        step();
        n_cmp++; if (out_br_taken !== 1'b0) begin n_fail++; $display("FAIL br_disabled: got %0b want 0", out_br_taken); end
        send(3'b000, 32'h0, 2'b00, 4'd0, 1'b0, 1'b1, 2'b11, 32'h380);
        step();
        n_cmp++; if (out_br_taken !== 1'b0) begin n_fail++; $display("FAIL br_gt_neg: got %0b want 0", out_br_taken); end
        send(3'b101, 32'h0, 2'b00, 4'd0, 1'b0, 1'b0, 2'b00, 32'h0);
        step();
        send(3'b000, 32'h0, 2'b00, 4'd0, 1'b0, 1'b1, 2'b11, 32'h400);
        step();
        n_cmp++; if (out_br_taken !== 1'b1) begin n_fail++; $display("FAIL br_gt_pos: got %0b want 1", out_br_taken); end
        n_cmp++; if (flags_q !== 2'b00) begin n_fail++; $display("FAIL br_flags: got %b want 00", flags_q); end
        idle();
        step();
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        send(3'b011, 32'h11, 2'b00, 4'd1, 1'b1, 1'b0, 2'b00, 32'h0);
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready1: got %0b want 1", in_ready); end
        send(3'b011, 32'h22, 2'b00, 4'd2, 1'b1, 1'b0, 2'b00, 32'h0);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_full: got %0b want 0", in_ready); end
        send(3'b011, 32'h33, 2'b00, 4'd3, 1'b1, 1'b0, 2'b00, 32'h0);
        step();
        n_cmp++; if (out_result !== 32'h11 || out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_hold: got v=%0b res=%h want v=1 res=11", out_valid, out_result); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_still_full: got %0b want 0", in_ready); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_result !== 32'h22 || out_rd !== 4'd2) begin n_fail++; $display("FAIL skid_second: got res=%h rd=%0d want 22/2", out_result, out_rd); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_freed: got %0b want 1", in_ready); end
        step();
        idle();
        n_cmp++; if (out_result !== 32'h33 || out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_third: got v=%0b res=%h want v=1 res=33", out_valid, out_result); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_full_cmp();
        out_ready = 1'b0;
        send(3'b011, 32'hA, 2'b00, 4'd1, 1'b1, 1'b0, 2'b00, 32'h0);
        step();
        send(3'b011, 32'hB, 2'b00, 4'd2, 1'b1, 1'b0, 2'b00, 32'h0);
        step();
        send(3'b101, 32'h0, 2'b01, 4'd0, 1'b0, 1'b0, 2'b00, 32'h0);
        step(); step();
        n_cmp++; if (flags_q !== 2'b00) begin n_fail++; $display("FAIL full_cmp_blocked: got %b want 00", flags_q); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (flags_q !== 2'b00) begin n_fail++; $display("FAIL full_cmp_pending: got %b want 00", flags_q); end
        step();
        idle();
        n_cmp++; if (flags_q !== 2'b01) begin n_fail++; $display("FAIL full_cmp_accepted: got %b want 01", flags_q); end
        step(); step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(3'b011, 32'hC, 2'b00, 4'd1, 1'b1, 1'b0, 2'b00, 32'h0);
        step();
        send(3'b011, 32'hD, 2'b00, 4'd2, 1'b1, 1'b0, 2'b00, 32'h0);
        step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %0b want 0", out_valid); end
        n_cmp++; if (flags_q !== 2'b00) begin n_fail++; $display("FAIL async_flags: got %b want 00", flags_q); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_in_ready: got %0b want 1", in_ready); end
`ifdef ALU_EX_PERF_CNT_EN
        n_cmp++; if (perf_stall_cnt !== 32'd0 || perf_br_taken_cnt !== 32'd0) begin
            n_fail++; $display("FAIL async_perf: got %0d/%0d want 0/0", perf_stall_cnt, perf_br_taken_cnt);
        end
`endif
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_no_drain: got %0b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_skid();
        test_full_cmp();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
